// File: rtl/svi_consistency_checker.sv
// Multi-channel consistency checker: compares channels against channel 0.
// Define SVI_CHK_CAPTURE_EN to build the capture register for the failing sample.
module svi_consistency_checker #(
  parameter int WIDTH = 1,
  parameter int NCH = 3,
  parameter logic [NCH-1:0] INV_MASK = '0,
  parameter int THRESH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic [NCH*WIDTH-1:0] i_data,
  input  logic                 i_clr,
  output logic [NCH-2:0]       o_mismatch,
  output logic [CNT_W-1:0]     o_err_cnt,
  output logic                 o_fail,
  output logic [1:0]           o_state,
  output logic [NCH*WIDTH-1:0] o_cap_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_FAIL  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

  state_t           r_state;
  logic [NCH-2:0]   r_mis;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_cons;

  logic [WIDTH-1:0] w_ch0;
  logic [NCH-2:0]   w_diff;
  logic             w_bad;
  logic             w_sample;
  logic             w_to_fail;

  assign w_ch0 = i_data[WIDTH-1:0];

  always_comb begin
    w_diff = '0;
    for (int k = 1; k < NCH; k++) begin
      w_diff[k-1] = i_data[k*WIDTH +: WIDTH]
                    != (INV_MASK[k] ? ~w_ch0 : w_ch0);
    end
  end

  assign w_sample  = (r_state == S_ARMED) && i_en && i_valid;
  assign w_bad     = |w_diff;
  // counter is always below THR while armed, so one more hit reaches it
  assign w_to_fail = w_sample && w_bad && (r_cons >= THR - CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_mis   <= '0;
      r_err   <= '0;
      r_cons  <= '0;
    end else if (i_clr) begin
      r_state <= i_en ? S_ARMED : S_IDLE;
      r_mis   <= '0;
      r_err   <= '0;
      r_cons  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_en) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (!i_en) begin
            r_state <= S_IDLE;
          end else if (i_valid) begin
            r_mis <= w_diff;
            if (w_bad) begin
              if (r_err != MAX) r_err <= r_err + CNT_W'(1);
              if (r_cons < THR) r_cons <= r_cons + CNT_W'(1);
              if (w_to_fail) r_state <= S_FAIL;
            end else begin
              r_cons <= '0;
            end
          end
        end
        S_FAIL: r_state <= S_FAIL;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SVI_CHK_CAPTURE_EN
  logic [NCH*WIDTH-1:0] r_cap;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cap <= '0;
    end else if (w_to_fail) begin
      r_cap <= i_data;
    end
  end

  assign o_cap_data = r_cap;
`else
  assign o_cap_data = '0;
`endif

  assign o_mismatch = r_mis;
  assign o_err_cnt  = r_err;
  assign o_fail     = (r_state == S_FAIL);
  assign o_state    = r_state;

endmodule

// File: tb/tb_svi_consistency_checker.sv
// Bench for svi_consistency_checker: scoreboard on the default instance,
// plus a small-counter / inverted-channel instance.
module tb_svi_consistency_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       en, valid, clr, rst;
  logic [2:0] data;
  logic [1:0] mis;
  logic [7:0] err;
  logic       fail;
  logic [1:0] st;
  logic [2:0] cap;

  logic       s_en, s_valid, s_clr, s_rst;
  logic [2:0] s_data;
  logic [1:0] s_mis;
  logic [1:0] s_err;
  logic       s_fail;
  logic [1:0] s_st;
  logic [2:0] s_cap;

  svi_consistency_checker dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_valid(valid),
    .i_data(data), .i_clr(clr), .o_mismatch(mis),
    .o_err_cnt(err), .o_fail(fail), .o_state(st),
    .o_cap_data(cap)
  );

  svi_consistency_checker #(
    .CNT_W(2), .THRESH(3), .INV_MASK(3'b010)
  ) dut_s (
    .i_clk(clk), .i_rst(s_rst), .i_en(s_en), .i_valid(s_valid),
    .i_data(s_data), .i_clr(s_clr), .o_mismatch(s_mis),
    .o_err_cnt(s_err), .o_fail(s_fail), .o_state(s_st),
    .o_cap_data(s_cap)
  );

  typedef struct {
    logic [1:0] mis;
    logic [7:0] err;
    logic       fail;
    logic [1:0] st;
    logic [2:0] cap;
  } exp_t;

  exp_t q[$];

  int n_tot = 0;
  int n_bad = 0;

  logic [1:0] m_st   = 2'b00;
  logic [1:0] m_mis  = '0;
  logic [7:0] m_err  = '0;
  int         m_cons = 0;
  logic [2:0] m_cap  = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference behaviour of the default-parameter checker
  task automatic model(input logic e, input logic v, input logic c,
                       input logic r, input logic [2:0] d);
    logic [1:0] df;
    df = {d[2] != d[0], d[1] != d[0]};
    if (r) begin
      m_st = 2'b00; m_mis = '0; m_err = '0; m_cons = 0; m_cap = '0;
    end else if (c) begin
      m_st = e ? 2'b01 : 2'b00;
      m_mis = '0; m_err = '0; m_cons = 0; m_cap = '0;
    end else if (m_st == 2'b00) begin
      if (e) m_st = 2'b01;
    end else if (m_st == 2'b01) begin
      if (!e) m_st = 2'b00;
      else if (v) begin
        m_mis = df;
        if (df != 2'b00) begin
          if (m_err != 8'hff) m_err = m_err + 8'd1;
          m_cons++;
          if (m_cons >= 4) begin
            m_st = 2'b10;
`ifdef SVI_CHK_CAPTURE_EN
            m_cap = d;
`endif
          end
        end else begin
          m_cons = 0;
        end
      end
    end
  endtask

  task automatic step(input logic e, input logic v, input logic c,
                      input logic r, input logic [2:0] d);
    exp_t x;
    @(negedge clk);
    en = e; valid = v; clr = c; rst = r; data = d;
    model(e, v, c, r, d);
    x.mis = m_mis; x.err = m_err; x.fail = (m_st == 2'b10);
    x.st = m_st; x.cap = m_cap;
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("mis", 32'(mis), 32'(x.mis));
    chk("err", 32'(err), 32'(x.err));
    chk("fail", 32'(fail), 32'(x.fail));
    chk("state", 32'(st), 32'(x.st));
    chk("cap", 32'(cap), 32'(x.cap));
  endtask

  task automatic s_step(input logic e, input logic v, input logic c,
                        input logic r, input logic [2:0] d);
    @(negedge clk);
    s_en = e; s_valid = v; s_clr = c; s_rst = r; s_data = d;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] cap_exp;

  initial begin
    en = 0; valid = 0; clr = 0; rst = 1; data = '0;
    s_en = 0; s_valid = 0; s_clr = 0; s_rst = 1; s_data = '0;
`ifdef SVI_CHK_CAPTURE_EN
    cap_exp = 3'b101;
`else
    cap_exp = 3'b000;
`endif

    step(0, 0, 0, 1, 3'b000);
    step(1, 1, 0, 1, 3'b011);
    chk("rst_state", 32'(st), 32'd0);

    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 3'b111);
    chk("match_state", 32'(st), 32'd1);
    chk("match_err", 32'(err), 32'd0);

    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 3'b011);
    step(1, 1, 0, 0, 3'b111);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 3'b011);
    chk("seq_err", 32'(err), 32'd6);
    chk("seq_mis", 32'(mis), 32'b10);

    step(1, 0, 0, 0, 3'b011);
    step(1, 0, 0, 0, 3'b101);
    chk("novalid_err", 32'(err), 32'd6);

    step(0, 1, 0, 0, 3'b101);
    step(0, 1, 0, 0, 3'b101);
    chk("idle_state", 32'(st), 32'd0);
    chk("idle_err", 32'(err), 32'd6);
    step(1, 1, 0, 0, 3'b110);

    step(1, 0, 1, 0, 3'b000);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 3'b101);
    chk("fail_flag", 32'(fail), 32'd1);
    chk("fail_err", 32'(err), 32'd4);
    chk("fail_state", 32'(st), 32'b10);
    chk("fail_cap", 32'(cap), 32'(cap_exp));
    for (int i = 0; i < 3; i++) step(i[0], 1, 0, 0, 3'b011);
    chk("fail_frozen", 32'(err), 32'd4);

    step(1, 1, 1, 0, 3'b101);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_state", 32'(st), 32'd1);

    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 3'b110);
    chk("fail2_state", 32'(st), 32'b10);
    step(1, 1, 1, 1, 3'b110);
    chk("rstf_state", 32'(st), 32'd0);
    chk("rstf_cap", 32'(cap), 32'd0);
    step(1, 0, 0, 0, 3'b000);
    chk("rel_state", 32'(st), 32'd1);

    for (int n = 0; n < 20; n++)
      step(($urandom_range(0, 7) != 0), $urandom_range(0, 1), 
           ($urandom_range(0, 9) == 0), 1'b0, 3'($urandom_range(0, 7)));

    s_step(0, 0, 0, 1, 3'b000);
    s_step(1, 0, 0, 0, 3'b000);
    for (int i = 0; i < 6; i++) begin
      s_step(1, 1, 0, 0, 3'b111);
      s_step(1, 1, 0, 0, 3'b101);
    end
    chk("sat_err", 32'(s_err), 32'd3);
    chk("sat_fail", 32'(s_fail), 32'd0);
    chk("inv_mis", 32'(s_mis), 32'd0);
    s_step(1, 1, 0, 0, 3'b111);
    chk("inv_mis1", 32'(s_mis), 32'b01);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/svi_consistency_checker.md
SVI_CONSISTENCY_CHECKER -- requirements
Module: svi_consistency_checker

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each channel.
REQ-002 Parameter NCH, default 3, legal range 2..16: channel count. Channel 0 is the reference; channels 1..NCH-1 are compared against it.
REQ-003 Parameter INV_MASK, NCH bits, default 0: bit k=1 means channel k is expected to equal the bitwise inverse of channel 0. Bit 0 is ignored.
REQ-004 Parameter THRESH, default 4, legal range 1..2^CNT_W-1: consecutive-mismatch count that forces FAIL.
REQ-005 Parameter CNT_W, default 8: width of the error counter.
REQ-006 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 i_rst  input  1  synchronous, active-high reset.
REQ-008 i_en  input  1  arms the checker.
REQ-009 i_valid  input  1  marks i_data as a sample for this cycle.
REQ-010 i_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 i_clr  input  1  clears the counters, the mismatch flags and FAIL.
REQ-012 o_mismatch  output  NCH-1  registered per-channel mismatch flags; bit k-1 corresponds to channel k.
REQ-013 o_err_cnt  output  CNT_W  saturating total count of mismatching samples.
REQ-014 o_fail  output  1  high while in the FAIL state.
REQ-015 o_state  output  2  encoding 00=IDLE, 01=ARMED, 10=FAIL.
REQ-016 o_cap_data  output  NCH*WIDTH  the sample that caused entry to FAIL (see Configuration).

Function
REQ-017 A sample mismatches when i_valid=1 and, for any k>=1, channel k != (INV_MASK[k] ? ~ch0 : ch0).
- All channels are checked in parallel.
- Any single bit difference counts.
REQ-018 o_mismatch updates only in ARMED on a valid sample, one cycle after that sample.
- It holds its value between samples.
REQ-019 Error counter behaviour:
- Increments by 1 per mismatching sample in ARMED.
- Saturates at 2^CNT_W-1 and never wraps.
REQ-020 Internal consecutive-mismatch counter:
- Increments on each mismatching sample.
- Clears on a matching valid sample.
- Holds on cycles with i_valid=0.
- Saturates at THRESH.
REQ-021 State IDLE -> ARMED when i_en=1.
REQ-022 State ARMED -> IDLE when i_en=0.
- Counters and flags hold their values.
- Samples are ignored while in IDLE.
REQ-023 State ARMED -> FAIL on the sample that makes the consecutive counter reach THRESH.
- o_fail=1 one cycle after that sample.
REQ-024 FAIL is sticky and ignores i_en.
- In FAIL, o_mismatch and o_err_cnt freeze and samples are ignored.
REQ-025 i_clr=1 has the following effect:
- Zeroes both counters, o_mismatch and o_cap_data.
- Next state is ARMED if i_en=1, otherwise IDLE.
- i_clr has priority over a simultaneous sample, the FAIL transition and an i_en change.
REQ-026 When a mismatch occurs with i_valid=0, nothing is counted.

Reset
REQ-027 Reset is synchronous: i_rst=1 at a rising edge forces IDLE on that edge, and all outputs read 0.
- Outputs reset: o_mismatch, o_err_cnt, o_fail, o_state, o_cap_data.
- Internal consecutive counter also resets to 0.
REQ-028 Reset has priority over i_clr, i_en and i_valid, including reset asserted while in FAIL.

Configuration
REQ-029 Macro SVI_CHK_CAPTURE_EN defined: o_cap_data loads i_data on the ARMED->FAIL sample and holds it until i_clr or reset.
REQ-030 Macro SVI_CHK_CAPTURE_EN undefined: o_cap_data is constant 0 and no capture register is built. All other behaviour is identical.

Verification
All scenarios use WIDTH=1, NCH=3, THRESH=4, CNT_W=8 and INV_MASK=0 unless stated otherwise.
REQ-031 Reset, i_en=1, i_data=3'b111 with i_valid=1 for 10 cycles -> o_state=01, o_mismatch=0, o_err_cnt=0, o_fail=0.
REQ-032 i_data=3'b011 for 3 samples, then 3'b111 for 1 sample, then 3'b011 for 3 samples -> o_err_cnt=6, o_mismatch=2'b10, o_state=01, no FAIL.
REQ-033 i_data=3'b101 for 4 consecutive samples -> o_fail=1 one cycle after the 4th sample, o_err_cnt=4, o_state=10, o_cap_data=3'b101 (0 if the macro is undefined); later samples leave o_err_cnt=4.
REQ-034 From FAIL, assert i_clr=1 in the same cycle as a mismatching valid sample with i_en=1 -> o_err_cnt=0, o_mismatch=0, o_fail=0, o_state=01.
REQ-035 CNT_W=2, THRESH=3, mismatching samples alternated with matching samples 6 times -> o_err_cnt saturates at 3, no FAIL; then INV_MASK=3'b010 with i_data=3'b101 -> no mismatch.
REQ-036 Assert i_rst while in FAIL with i_en=1 and i_clr=1 -> next cycle o_state=00 and all outputs 0; o_state=01 one cycle after i_rst deasserts.
